alu_vector_driver: RTL and testbench

- Sequential stimulus generator and response checker for the Control+ALU pair. It drives the same interface a testbench drives by hand.
- Reads test vectors from an external synchronous ROM. Each vector holds OpCode, Funct, Data_A, Data_B and the expected Z.
- Presents each vector to Control/ALU, waits a settle time, then compares the ALU result.
- Used for on-chip built-in self-test of the execute stage and in regression benches.

---
 rtl/alu_vector_driver.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_vector_driver.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_vector_driver.sv
// alu_vector_driver: built-in self-test sequencer for the Control+ALU pair.
// It fetches vectors from a synchronous ROM and drives OpCode/Funct/A/B.
// After a settle time it checks Z against the expected value. It records the
// mismatch count and the index of the first failing vector.
module alu_vector_driver #(
  parameter int NUM_VEC    = 48,
  parameter int ADDR_W     = 6,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              vec_rd,
  input  logic [107:0]      vec_data,
  output logic [5:0]        OpCode,
  output logic [5:0]        Funct,
  output logic [31:0]       Data_A,
  output logic [31:0]       Data_B,
  input  logic [31:0]       Z,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        fail_count,
  output logic [ADDR_W-1:0] first_fail
);

  // The index register must never wrap, and the settle counter is 4 bits wide.
  generate
    if (NUM_VEC < 1 || NUM_VEC > (1 << ADDR_W) || SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_param
      $error("alu_vector_driver: illegal NUM_VEC/ADDR_W/SETTLE_CYC combination");
    end
  endgenerate

  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_VEC - 1);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DRIVE  = 3'd3,
    ST_SETTLE = 3'd4,
    ST_CHECK  = 3'd5,
    ST_FINISH = 3'd6
  } state_t;

  state_t             state_r;
  state_t             fsm_next_s;
  state_t             state_next_s;
  logic [ADDR_W-1:0]  idx_r;
  logic [3:0]         settle_cnt_r;
  logic [31:0]        exp_r;
  logic               vec_rd_r;
  logic               busy_r;
  logic               done_r;
  logic               pass_r;
  logic [7:0]         fail_count_r;
  logic [ADDR_W-1:0]  first_fail_r;
  logic [5:0]         opcode_r;
  logic [5:0]         funct_r;
  logic [31:0]        data_a_r;
  logic [31:0]        data_b_r;
  logic               abort_s;
  logic               accept_s;
  logic               finish_s;
  logic               mismatch_s;

  // abort only matters once a run is in progress; it also overrides start.
  assign abort_s      = abort && (state_r != ST_IDLE);
  assign state_next_s = abort_s ? ST_IDLE : fsm_next_s;
  assign accept_s     = (state_r == ST_IDLE) && (state_next_s == ST_FETCH);
  assign finish_s     = (state_next_s == ST_FINISH);

  // Next-state sequencing through fetch / ROM latency / drive / settle / check.
  always_comb begin
    fsm_next_s = state_r;
    mismatch_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          fsm_next_s = ST_FETCH;
        end else begin
          fsm_next_s = ST_IDLE;
        end
      end
      ST_FETCH:  fsm_next_s = ST_WAIT;
      ST_WAIT:   fsm_next_s = ST_DRIVE;
      ST_DRIVE:  fsm_next_s = ST_SETTLE;
      ST_SETTLE: begin
        if (settle_cnt_r == SETTLE_LAST) begin
          fsm_next_s = ST_CHECK;
        end else begin
          fsm_next_s = ST_SETTLE;
        end
      end
      ST_CHECK: begin
        mismatch_s = (Z != exp_r);
        if (idx_r == LAST_IDX) begin
          fsm_next_s = ST_FINISH;
        end else begin
          fsm_next_s = ST_FETCH;
        end
      end
      ST_FINISH: fsm_next_s = ST_IDLE;
      default:   fsm_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Sequencing outputs: ROM strobe, done pulse, busy, vector index and settle count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec_rd_r     <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      idx_r        <= {ADDR_W{1'b0}};
      settle_cnt_r <= 4'd0;
    end else begin
      vec_rd_r <= (state_next_s == ST_FETCH);
      done_r   <= finish_s;
      if (state_r == ST_SETTLE) begin
        settle_cnt_r <= settle_cnt_r + 4'd1;
      end else begin
        settle_cnt_r <= 4'd0;
      end
      if (accept_s) begin
        busy_r <= 1'b1;
        idx_r  <= {ADDR_W{1'b0}};
      end else if (abort_s || finish_s) begin
        busy_r <= 1'b0;
      end else if (state_r == ST_CHECK) begin
        idx_r <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // Operand outputs: loaded from ROM in DRIVE, held, and returned to nop when the run ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opcode_r <= 6'd0;
      funct_r  <= 6'd0;
      data_a_r <= 32'd0;
      data_b_r <= 32'd0;
      exp_r    <= 32'd0;
    end else if (abort_s || finish_s) begin
      opcode_r <= 6'd0;
      funct_r  <= 6'd0;
      data_a_r <= 32'd0;
      data_b_r <= 32'd0;
    end else if (state_r == ST_DRIVE) begin
      opcode_r <= vec_data[107:102];
      funct_r  <= vec_data[101:96];
      data_a_r <= vec_data[95:64];
      data_b_r <= vec_data[63:32];
      exp_r    <= vec_data[31:0];
    end else begin
      opcode_r <= opcode_r;
    end
  end

  // Result bookkeeping: saturating mismatch count, first failing index, final verdict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_r       <= 1'b0;
      fail_count_r <= 8'd0;
      first_fail_r <= {ADDR_W{1'b0}};
    end else if (accept_s) begin
      pass_r       <= 1'b0;
      fail_count_r <= 8'd0;
      first_fail_r <= {ADDR_W{1'b0}};
    end else if (abort_s) begin
      pass_r <= 1'b0;
    end else begin
      if (mismatch_s) begin
        if (fail_count_r == 8'd0) begin
          first_fail_r <= idx_r;
        end else begin
          first_fail_r <= first_fail_r;
        end
        if (fail_count_r != 8'hFF) begin
          fail_count_r <= fail_count_r + 8'd1;
        end else begin
          fail_count_r <= fail_count_r;
        end
      end else begin
        fail_count_r <= fail_count_r;
      end
      if (finish_s) begin
        pass_r <= (fail_count_r == 8'd0) && !mismatch_s;
      end else begin
        pass_r <= pass_r;
      end
    end
  end

  assign vec_addr   = idx_r;
  assign vec_rd     = vec_rd_r;
  assign OpCode     = opcode_r;
  assign Funct      = funct_r;
  assign Data_A     = data_a_r;
  assign Data_B     = data_b_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign fail_count = fail_count_r;
  assign first_fail = first_fail_r;

endmodule

// File: tb/tb_alu_vector_driver.sv
// Bench for alu_vector_driver. Instance a runs 3 vectors with a settle time of 1.
// Instance b runs 300 vectors with ADDR_W=9 and a settle time of 2.
// A run-schedule model predicts every output on every cycle from the vector table.
module tb_alu_vector_driver;

  localparam int NV_A = 3;
  localparam int P_A  = 5;
  localparam int NV_B = 300;
  localparam int P_B  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_v [2];
  logic abort_v [2];

  logic [5:0]   vec_addr_a, op_a, fn_a, ff_a;
  logic [8:0]   vec_addr_b, ff_b;
  logic [5:0]   op_b, fn_b;
  logic         vec_rd_a, vec_rd_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [107:0] vec_data_a = '0;
  logic [107:0] vec_data_b = '0;
  logic [31:0]  da_a, db_a, z_a, da_b, db_b, z_b;
  logic [7:0]   fc_a, fc_b;

  logic [5:0]  rom_op [512];
  logic [5:0]  rom_fn [512];
  logic [31:0] rom_a  [512];
  logic [31:0] rom_b  [512];
  logic [31:0] rom_e  [512];

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  logic run_m   [2];
  int   t0_m    [2];
  int   hfc_m   [2];
  int   hff_m   [2];
  logic hpass_m [2];
  int done_cnt [2] = '{0, 0};
  int done_off [2] = '{0, 0};

  alu_vector_driver #(.NUM_VEC(NV_A), .ADDR_W(6), .SETTLE_CYC(1)) u_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort_v[0]),
    .vec_addr(vec_addr_a), .vec_rd(vec_rd_a), .vec_data(vec_data_a),
    .OpCode(op_a), .Funct(fn_a), .Data_A(da_a), .Data_B(db_a), .Z(z_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(fc_a), .first_fail(ff_a));

  alu_vector_driver #(.NUM_VEC(NV_B), .ADDR_W(9), .SETTLE_CYC(2)) u_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort_v[1]),
    .vec_addr(vec_addr_b), .vec_rd(vec_rd_b), .vec_data(vec_data_b),
    .OpCode(op_b), .Funct(fn_b), .Data_A(da_b), .Data_B(db_b), .Z(z_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_count(fc_b), .first_fail(ff_b));

  // Reference ALU: R-type add/sub/and/or, everything else yields zero.
  function automatic logic [31:0] alu(input logic [5:0] op, input logic [5:0] fn,
                                      input logic [31:0] a, input logic [31:0] b);
    if (op != 6'd0) return 32'd0;
    case (fn)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      default: return 32'd0;
    endcase
  endfunction

  assign z_a = alu(op_a, fn_a, da_a, db_a);
  assign z_b = alu(op_b, fn_b, da_b, db_b);

  // Synchronous ROMs: the word is registered on the strobe and held afterwards.
  always @(posedge clk) begin
    if (vec_rd_a) vec_data_a <= {rom_op[{3'd0, vec_addr_a}], rom_fn[{3'd0, vec_addr_a}],
                                 rom_a[{3'd0, vec_addr_a}], rom_b[{3'd0, vec_addr_a}], rom_e[{3'd0, vec_addr_a}]};
    if (vec_rd_b) vec_data_b <= {rom_op[vec_addr_b], rom_fn[vec_addr_b],
                                 rom_a[vec_addr_b], rom_b[vec_addr_b], rom_e[vec_addr_b]};
  end

  function automatic int nv_of(input int i);
    return (i == 0) ? NV_A : NV_B;
  endfunction

  function automatic int per_of(input int i);
    return (i == 0) ? P_A : P_B;
  endfunction

  function automatic logic mis(input int j);
    return alu(rom_op[j], rom_fn[j], rom_a[j], rom_b[j]) != rom_e[j];
  endfunction

  // Mismatches among vectors 0..m-1, saturating at 255.
  function automatic int cnt_mis(input int m);
    int n = 0;
    for (int j = 0; j < m; j++) if (mis(j) && n < 255) n++;
    return n;
  endfunction

  function automatic int first_mis(input int m);
    for (int j = 0; j < m; j++) if (mis(j)) return j;
    return 0;
  endfunction

  task automatic cmp(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s inst%0d cyc%0d: got 0x%0h, want 0x%0h", nm, i, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Run-schedule model: tracks accepted runs, their end, aborts and reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        run_m[i] <= 1'b0; t0_m[i] <= 0; hfc_m[i] <= 0; hff_m[i] <= 0; hpass_m[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!run_m[i]) begin
          if (start_v[i] && !abort_v[i]) begin
            run_m[i] <= 1'b1;
            t0_m[i]  <= cyc + 1;
          end
        end else if (abort_v[i]) begin
          run_m[i]   <= 1'b0;
          hfc_m[i]   <= cnt_mis((cyc - t0_m[i]) / per_of(i));
          hff_m[i]   <= first_mis((cyc - t0_m[i]) / per_of(i));
          hpass_m[i] <= 1'b0;
        end else if (cyc + 1 - t0_m[i] == nv_of(i) * per_of(i) + 1) begin
          run_m[i]   <= 1'b0;
          hfc_m[i]   <= cnt_mis(nv_of(i));
          hff_m[i]   <= first_mis(nv_of(i));
          hpass_m[i] <= (cnt_mis(nv_of(i)) == 0);
        end
      end
    end
  end

  task automatic chk(input int i, input logic rd, input logic [8:0] addr, input logic [5:0] op,
                     input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                     input logic bsy, input logic dn, input logic ps, input logic [7:0] fc,
                     input logic [8:0] ff);
    int off, k, ph, src;
    logic e_rd, e_busy, e_done, e_pass;
    logic [31:0] e_op, e_fn, e_a, e_b;
    int e_fc, e_ff;
    e_rd = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_pass = hpass_m[i];
    e_fc = hfc_m[i]; e_ff = hff_m[i];
    e_op = 32'd0; e_fn = 32'd0; e_a = 32'd0; e_b = 32'd0;
    if (run_m[i]) begin
      off = cyc - t0_m[i];
      if (off < nv_of(i) * per_of(i)) begin
        k = off / per_of(i);
        ph = off % per_of(i);
        e_busy = 1'b1; e_pass = 1'b0; e_rd = (ph == 0);
        e_fc = cnt_mis(k); e_ff = first_mis(k);
        src = (ph >= 3) ? k : k - 1;
        if (src >= 0) begin
          e_op = 32'(rom_op[src]); e_fn = 32'(rom_fn[src]); e_a = rom_a[src]; e_b = rom_b[src];
        end
        if (ph == 0) cmp("vec_addr", i, 32'(addr), 32'(k));
      end else begin
        e_done = 1'b1;
        e_fc = cnt_mis(nv_of(i)); e_ff = first_mis(nv_of(i)); e_pass = (e_fc == 0);
      end
    end
    cmp("vec_rd", i, 32'(rd), 32'(e_rd));
    cmp("busy", i, 32'(bsy), 32'(e_busy));
    cmp("done", i, 32'(dn), 32'(e_done));
    cmp("pass", i, 32'(ps), 32'(e_pass));
    cmp("fail_count", i, 32'(fc), 32'(e_fc));
    cmp("first_fail", i, 32'(ff), 32'(e_ff));
    cmp("OpCode", i, 32'(op), e_op);
    cmp("Funct", i, 32'(fn), e_fn);
    cmp("Data_A", i, a, e_a);
    cmp("Data_B", i, b, e_b);
  endtask

  // Compare process: all outputs of both instances against the model, every cycle.
  always @(negedge clk) begin
    chk(0, vec_rd_a, {3'd0, vec_addr_a}, op_a, fn_a, da_a, db_a, busy_a, done_a, pass_a, fc_a, {3'd0, ff_a});
    chk(1, vec_rd_b, vec_addr_b, op_b, fn_b, da_b, db_b, busy_b, done_b, pass_b, fc_b, ff_b);
  end

  // Done pulse counter and its offset from start acceptance.
  always @(negedge clk) begin
    if (done_a) begin done_cnt[0] <= done_cnt[0] + 1; done_off[0] <= cyc - t0_m[0]; end
    if (done_b) begin done_cnt[1] <= done_cnt[1] + 1; done_off[1] <= cyc - t0_m[1]; end
  end

  task automatic pulse(input int i);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int t = 0;
    while (run_m[i] && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (run_m[i]) cmp("timeout_idle", i, 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_off(input int i, input int target);
    logic ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (run_m[i] && (cyc - t0_m[i]) == target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) cmp("timeout_off", i, 32'd1, 32'd0);
  endtask

  task automatic set_vec(input int j, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e);
    rom_op[j] = 6'd0; rom_fn[j] = fn; rom_a[j] = a; rom_b[j] = b; rom_e[j] = e;
  endtask

  initial begin : stim
    int n;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin start_v[i] = 1'b0; abort_v[i] = 1'b0; end
    for (int j = 0; j < 512; j++) set_vec(j, 6'd0, 32'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    cmp("rst_busy", 0, 32'(busy_a), 32'd0);
    cmp("rst_fail_count", 0, 32'(fc_a), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Three vectors, the middle one carrying a wrong expected value.
    set_vec(0, 6'h20, 32'd3, 32'd5, 32'd8);
    set_vec(1, 6'h20, 32'd3, 32'd5, 32'd9);
    set_vec(2, 6'h22, 32'd10, 32'd4, 32'd6);
    pulse(0);
    wait_idle(0, 100);
    cmp("run1_done_cnt", 0, 32'(done_cnt[0]), 32'd1);
    cmp("run1_done_off", 0, 32'(done_off[0]), 32'd15);
    cmp("run1_pass", 0, 32'(pass_a), 32'd0);
    cmp("run1_fail_count", 0, 32'(fc_a), 32'd1);
    cmp("run1_first_fail", 0, 32'(ff_a), 32'd1);

    // All-good table, start held high: back-to-back runs, start ignored while busy.
    rom_e[1] = 32'd8;
    start_v[0] = 1'b1;
    n = 0;
    for (int t = 0; t < 100 && n < 2; t++) begin
      @(negedge clk);
      if (done_a) n++;
    end
    start_v[0] = 1'b0;
    cmp("retrigger_runs", 0, 32'(n), 32'd2);
    wait_idle(0, 100);
    cmp("run2_pass", 0, 32'(pass_a), 32'd1);
    cmp("run2_fail_count", 0, 32'(fc_a), 32'd0);
    cmp("run2_done_cnt", 0, 32'(done_cnt[0]), 32'd3);

    // Abort during SETTLE of the third vector; a start pulse mid-run is ignored.
    rom_e[1] = 32'd9;
    pulse(0);
    wait_off(0, 5);
    pulse(0);
    wait_off(0, 13);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    cmp("abort_busy", 0, 32'(busy_a), 32'd0);
    cmp("abort_done", 0, 32'(done_a), 32'd0);
    cmp("abort_data_a", 0, da_a, 32'd0);
    cmp("abort_data_b", 0, db_a, 32'd0);
    cmp("abort_fail_count", 0, 32'(fc_a), 32'd1);
    cmp("abort_first_fail", 0, 32'(ff_a), 32'd1);
    repeat (10) @(negedge clk);
    cmp("abort_no_done", 0, 32'(done_cnt[0]), 32'd3);

    // Asynchronous reset during DRIVE of the second vector.
    pulse(0);
    wait_off(0, 7);
    cmp("pre_rst_data_a", 0, da_a, 32'd3);
    cmp("pre_rst_busy", 0, 32'(busy_a), 32'd1);
    #2 reset = 1'b0;
    #1;
    cmp("arst_busy", 0, 32'(busy_a), 32'd0);
    cmp("arst_vec_rd", 0, 32'(vec_rd_a), 32'd0);
    cmp("arst_opcode", 0, 32'({op_a, fn_a}), 32'd0);
    cmp("arst_data_a", 0, da_a, 32'd0);
    cmp("arst_fail_count", 0, 32'(fc_a), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 300-vector runs on the wide instance: all good, two bad, all bad.
    for (int j = 0; j < 300; j++) begin
      case (j % 4)
        0: rom_fn[j] = 6'h20;
        1: rom_fn[j] = 6'h22;
        2: rom_fn[j] = 6'h24;
        default: rom_fn[j] = 6'h25;
      endcase
      set_vec(j, rom_fn[j], 32'(j * 7 + 1), 32'(j * 3 + 2), 32'd0);
      rom_e[j] = alu(6'd0, rom_fn[j], rom_a[j], rom_b[j]);
    end
    pulse(1);
    wait_idle(1, 2000);
    cmp("b_good_pass", 1, 32'(pass_b), 32'd1);
    cmp("b_good_fail_count", 1, 32'(fc_b), 32'd0);
    cmp("b_good_done_off", 1, 32'(done_off[1]), 32'd1800);

    rom_e[2] = rom_e[2] ^ 32'd1;
    rom_e[4] = rom_e[4] ^ 32'd1;
    pulse(1);
    wait_idle(1, 2000);
    cmp("b_two_fail_count", 1, 32'(fc_b), 32'd2);
    cmp("b_two_first_fail", 1, 32'(ff_b), 32'd2);
    cmp("b_two_pass", 1, 32'(pass_b), 32'd0);

    for (int j = 0; j < 300; j++) rom_e[j] = ~alu(6'd0, rom_fn[j], rom_a[j], rom_b[j]);
    pulse(1);
    wait_idle(1, 2000);
    cmp("b_sat_fail_count", 1, 32'(fc_b), 32'd255);
    cmp("b_sat_first_fail", 1, 32'(ff_b), 32'd0);
    cmp("b_sat_pass", 1, 32'(pass_b), 32'd0);
    cmp("b_done_cnt", 1, 32'(done_cnt[1]), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    n_mis++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
